mest_pro_sequencer: RTL and testbench



---
 rtl/mest_pro_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_mest_pro_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mest_pro_sequencer.sv
// mest_pro_sequencer: instruction sequencer for the MEST Pro core.
// Fetches 28-bit instructions from a one-cycle-latency ROM, decodes the
// opcode, issues ALU operations over valid/ready and resolves jumps and
// conditional branches on the registered zero/carry flags.
// Optional feature: define MEST_SEQ_WATCHDOG_EN to enable a WAIT_RES
// watchdog that aborts to DONE with o_error set after WDOG_CYCLES cycles.
module mest_pro_sequencer #(
  parameter int OP_CODE_SIZE     = 4,
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = 16,
  parameter int INSTRUCTION_SIZE = OP_CODE_SIZE + 3 * DATA_WIDTH,
  parameter int WDOG_CYCLES      = 255
) (
  input  logic                        clk,
  input  logic                        i_reset_n,
  input  logic                        i_start,
  output logic                        o_rom_en,
  output logic [ADDR_WIDTH-1:0]       o_rom_addr,
  input  logic [INSTRUCTION_SIZE-1:0] i_rom_data,
  output logic                        o_alu_valid,
  input  logic                        i_alu_ready,
  output logic [OP_CODE_SIZE-1:0]     o_alu_op,
  output logic [DATA_WIDTH-1:0]       o_alu_a,
  output logic [DATA_WIDTH-1:0]       o_alu_b,
  output logic [DATA_WIDTH-1:0]       o_alu_c,
  input  logic                        i_alu_done,
  input  logic                        i_alu_zero,
  input  logic                        i_alu_carry,
  output logic [ADDR_WIDTH-1:0]       o_pc,
  output logic                        o_busy,
  output logic                        o_all_done,
  output logic                        o_error
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_LATCH    = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_ISSUE    = 3'd4;
  localparam logic [2:0] S_WAIT_RES = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [OP_CODE_SIZE-1:0] OP_HALT = OP_CODE_SIZE'(4'hF);
  localparam logic [OP_CODE_SIZE-1:0] OP_JMP  = OP_CODE_SIZE'(4'hE);
  localparam logic [OP_CODE_SIZE-1:0] OP_JZ   = OP_CODE_SIZE'(4'hD);
  localparam logic [OP_CODE_SIZE-1:0] OP_JC   = OP_CODE_SIZE'(4'hC);

  logic [2:0]                  state_r, state_nxt;
  logic [ADDR_WIDTH-1:0]       pc_r, pc_nxt;
  logic                        zero_r, zero_nxt;
  logic                        carry_r, carry_nxt;
  logic [INSTRUCTION_SIZE-1:0] ir_r;
  logic [OP_CODE_SIZE-1:0]     ir_op_s;
  logic [DATA_WIDTH-1:0]       ir_a_s, ir_b_s, ir_c_s;
  logic [ADDR_WIDTH-1:0]       target_s;
  logic                        pc_last_s;
  logic [2:0]                  adv_state_s;
  logic [ADDR_WIDTH-1:0]       adv_pc_s;
  logic                        start_s;

  assign ir_op_s  = ir_r[INSTRUCTION_SIZE-1 -: OP_CODE_SIZE];
  assign ir_a_s   = ir_r[3*DATA_WIDTH-1 -: DATA_WIDTH];
  assign ir_b_s   = ir_r[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign ir_c_s   = ir_r[DATA_WIDTH-1:0];
  assign target_s = ADDR_WIDTH'({ir_b_s, ir_c_s});

  // Sequential advance: stepping past the last address halts instead of wrapping.
  assign pc_last_s   = (pc_r == {ADDR_WIDTH{1'b1}});
  assign adv_state_s = pc_last_s ? S_DONE : S_FETCH;
  assign adv_pc_s    = pc_last_s ? pc_r : pc_r + ADDR_WIDTH'(1);

  assign start_s = i_start && ((state_r == S_IDLE) || (state_r == S_DONE));

`ifdef MEST_SEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt_r;
  logic              wdog_expired_s;
  logic              error_r;

  assign wdog_expired_s = (wdog_cnt_r == WDOG_W'(WDOG_CYCLES - 1));

  // Watchdog counter: held at zero outside WAIT_RES, counts cycles spent waiting.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wdog_cnt_r <= '0;
    end else if (state_r != S_WAIT_RES) begin
      wdog_cnt_r <= '0;
    end else if (!wdog_expired_s) begin
      wdog_cnt_r <= wdog_cnt_r + WDOG_W'(1);
    end else begin
      wdog_cnt_r <= wdog_cnt_r;
    end
  end

  // Sticky timeout flag, cleared only by an accepted start.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      error_r <= 1'b0;
    end else if (start_s) begin
      error_r <= 1'b0;
    end else if ((state_r == S_WAIT_RES) && !i_alu_done && wdog_expired_s) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end

  assign o_error = error_r;
`else
  assign o_error = 1'b0;
`endif

  // Next-state, PC and flag computation.
  always_comb begin
    state_nxt = state_r;
    pc_nxt    = pc_r;
    zero_nxt  = zero_r;
    carry_nxt = carry_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
          zero_nxt  = 1'b0;
          carry_nxt = 1'b0;
        end else begin
          state_nxt = state_r;
        end
      end
      S_FETCH: state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_EXEC;
      S_EXEC: begin
        case (ir_op_s)
          OP_HALT: state_nxt = S_DONE;
          OP_JMP: begin
            state_nxt = S_FETCH;
            pc_nxt    = target_s;
          end
          OP_JZ, OP_JC: begin
            if ((ir_op_s == OP_JZ) ? zero_r : carry_r) begin
              state_nxt = S_FETCH;
              pc_nxt    = target_s;
            end else begin
              state_nxt = adv_state_s;
              pc_nxt    = adv_pc_s;
            end
          end
          default: state_nxt = S_ISSUE;
        endcase
      end
      S_ISSUE: begin
        if (i_alu_ready) begin
          state_nxt = S_WAIT_RES;
        end else begin
          state_nxt = S_ISSUE;
        end
      end
      S_WAIT_RES: begin
        if (i_alu_done) begin
          zero_nxt  = i_alu_zero;
          carry_nxt = i_alu_carry;
          state_nxt = adv_state_s;
          pc_nxt    = adv_pc_s;
        end
`ifdef MEST_SEQ_WATCHDOG_EN
        else if (wdog_expired_s) begin
          state_nxt = S_DONE;
        end
`endif
        else begin
          state_nxt = S_WAIT_RES;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Core state, PC, flags and status outputs registered from the next state.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r     <= S_IDLE;
      pc_r        <= '0;
      zero_r      <= 1'b0;
      carry_r     <= 1'b0;
      o_rom_en    <= 1'b0;
      o_alu_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_all_done  <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      pc_r        <= pc_nxt;
      zero_r      <= zero_nxt;
      carry_r     <= carry_nxt;
      o_rom_en    <= (state_nxt == S_FETCH);
      o_alu_valid <= (state_nxt == S_ISSUE);
      o_busy      <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      o_all_done  <= (state_nxt == S_DONE);
    end
  end

  // Instruction register loads the ROM word in LATCH.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ir_r <= '0;
    end else if (state_r == S_LATCH) begin
      ir_r <= i_rom_data;
    end else begin
      ir_r <= ir_r;
    end
  end

  // ALU request fields load when entering ISSUE and hold afterwards.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_alu_op <= '0;
      o_alu_a  <= '0;
      o_alu_b  <= '0;
      o_alu_c  <= '0;
    end else if ((state_r == S_EXEC) && (state_nxt == S_ISSUE)) begin
      o_alu_op <= ir_op_s;
      o_alu_a  <= ir_a_s;
      o_alu_b  <= ir_b_s;
      o_alu_c  <= ir_c_s;
    end else begin
      o_alu_op <= o_alu_op;
      o_alu_a  <= o_alu_a;
      o_alu_b  <= o_alu_b;
      o_alu_c  <= o_alu_c;
    end
  end

  assign o_rom_addr = pc_r;
  assign o_pc       = pc_r;

endmodule

// File: tb/tb_mest_pro_sequencer.sv
// Directed self-checking bench for mest_pro_sequencer: a behavioural ROM with
// one-cycle read latency and an ALU driven step by step from the stimulus.
module tb_mest_pro_sequencer;
  localparam int OPW = 4;
  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int IW  = 28;
`ifdef MEST_SEQ_WATCHDOG_EN
  localparam int WDOG_TB = 10;
`else
  localparam int WDOG_TB = 255;
`endif

  logic          clk = 1'b0;
  logic          i_reset_n;
  logic          i_start;
  logic          o_rom_en;
  logic [AW-1:0] o_rom_addr;
  logic [IW-1:0] i_rom_data = '0;
  logic          o_alu_valid;
  logic          i_alu_ready;
  logic [OPW-1:0] o_alu_op;
  logic [DW-1:0] o_alu_a, o_alu_b, o_alu_c;
  logic          i_alu_done, i_alu_zero, i_alu_carry;
  logic [AW-1:0] o_pc;
  logic          o_busy, o_all_done, o_error;

  logic [IW-1:0] rom [0:65535];
  int checks;
  int errors;
  int hs_cnt     = 0;
  int fetch0_cnt = 0;
  int hs0;
  int f0;

  always #5 clk = ~clk;

  mest_pro_sequencer #(.WDOG_CYCLES(WDOG_TB)) dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_start(i_start),
    .o_rom_en(o_rom_en), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .o_alu_valid(o_alu_valid), .i_alu_ready(i_alu_ready),
    .o_alu_op(o_alu_op), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_c(o_alu_c),
    .i_alu_done(i_alu_done), .i_alu_zero(i_alu_zero), .i_alu_carry(i_alu_carry),
    .o_pc(o_pc), .o_busy(o_busy), .o_all_done(o_all_done), .o_error(o_error)
  );

  // ROM with one-cycle read latency.
  always @(posedge clk) if (o_rom_en) i_rom_data <= rom[o_rom_addr];

  // Count accepted ALU handshakes and fetches of address 0.
  always @(posedge clk) begin
    if (o_alu_valid && i_alu_ready) hs_cnt <= hs_cnt + 1;
    if (o_rom_en && (o_rom_addr == 16'h0000)) fetch0_cnt <= fetch0_cnt + 1;
  end

  function automatic logic [IW-1:0] ins(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c);
    return {op, a, b, c};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc"}, 32'(o_pc), 32'd0);
    chk({tag, "_rom"}, 32'({o_rom_en, o_rom_addr}), 32'd0);
    chk({tag, "_alu"}, 32'({o_alu_valid, o_alu_op, o_alu_a, o_alu_b, o_alu_c}), 32'd0);
    chk({tag, "_stat"}, 32'({o_busy, o_all_done, o_error}), 32'd0);
  endtask

  // Program: ALU op, then JZ/JC to 0x0010; fall-through lands at 2.
  task automatic run_branch(input string tag, input logic [3:0] op, input logic z,
                            input logic c, input logic [15:0] exp_addr);
    rom[0]  = ins(4'h2, 8'd5, 8'd5, 8'd0);
    rom[1]  = ins(op, 8'h00, 8'h00, 8'h10);
    rom[2]  = ins(4'hF, 8'd0, 8'd0, 8'd0);
    rom[16] = ins(4'hF, 8'd0, 8'd0, 8'd0);
    i_start = 1'b1; tick; i_start = 1'b0;          // FETCH 0
    chk({tag, "_done_clr"}, 32'(o_all_done), 32'd0);
    tick; tick; tick;                              // LATCH, EXEC, ISSUE
    i_alu_ready = 1'b1; tick; i_alu_ready = 1'b0;  // WAIT_RES
    i_alu_done = 1'b1; i_alu_zero = z; i_alu_carry = c;
    tick;                                          // FETCH 1
    i_alu_done = 1'b0; i_alu_zero = 1'b0; i_alu_carry = 1'b0;
    tick; tick; tick;                              // LATCH, EXEC, FETCH target
    chk({tag, "_fetch"}, 32'({o_rom_en, o_rom_addr}), 32'({1'b1, exp_addr}));
    tick; tick; tick;                              // LATCH, EXEC, DONE
    chk({tag, "_done"}, 32'(o_all_done), 32'd1);
    chk({tag, "_pc"}, 32'(o_pc), 32'(exp_addr));
  endtask

  initial begin
    checks = 0; errors = 0;
    i_reset_n = 1'b0; i_start = 1'b0; i_alu_ready = 1'b0;
    i_alu_done = 1'b0; i_alu_zero = 1'b0; i_alu_carry = 1'b0;
    for (int i = 0; i < 65536; i++) rom[i] = ins(4'hF, 8'd0, 8'd0, 8'd0);

    // Reset state.
    tick; tick;
    chk_all_zero("reset");
    i_reset_n = 1'b1;
    tick;
    chk("idle_busy", 32'(o_busy), 32'd0);

    // Basic program: ADD 3,4 then HALT. ALU instruction 5 cycles, HALT 3.
    rom[0] = ins(4'h1, 8'd3, 8'd4, 8'd9);
    rom[1] = ins(4'hF, 8'd0, 8'd0, 8'd0);
    hs0 = hs_cnt;
    i_start = 1'b1; tick; i_start = 1'b0;          // FETCH
    chk("a_fetch", 32'({o_rom_en, o_rom_addr, o_busy}), 32'({1'b1, 16'h0000, 1'b1}));
    tick;                                          // LATCH
    chk("a_latch_en", 32'(o_rom_en), 32'd0);
    tick; tick;                                    // EXEC, ISSUE
    chk("a_valid", 32'(o_alu_valid), 32'd1);
    chk("a_fields", 32'({o_alu_op, o_alu_a, o_alu_b, o_alu_c}), 32'({4'h1, 8'd3, 8'd4, 8'd9}));
    i_alu_ready = 1'b1; tick; i_alu_ready = 1'b0;  // WAIT_RES
    chk("a_valid_drop", 32'(o_alu_valid), 32'd0);
    chk("a_hold_a", 32'(o_alu_a), 32'd3);
    i_alu_done = 1'b1; tick; i_alu_done = 1'b0;    // FETCH 1
    chk("a_fetch1", 32'({o_rom_en, o_pc}), 32'({1'b1, 16'h0001}));
    tick; tick;                                    // LATCH, EXEC
    chk("a_not_done", 32'(o_all_done), 32'd0);
    tick;                                          // DONE
    chk("a_done", 32'({o_all_done, o_busy}), 32'({1'b1, 1'b0}));
    chk("a_pc", 32'(o_pc), 32'd1);
    chk("a_hs", 32'(hs_cnt - hs0), 32'd1);

    // Conditional branches on the registered flags.
    run_branch("jz_t", 4'hD, 1'b1, 1'b0, 16'h0010);
    run_branch("jz_n", 4'hD, 1'b0, 1'b1, 16'h0002);
    run_branch("jc_t", 4'hC, 1'b0, 1'b1, 16'h0010);
    run_branch("jc_n", 4'hC, 1'b1, 1'b0, 16'h0002);

    // Backpressure: 7 cycles not ready, start ignored while busy,
    // done in the handshake cycle not captured.
    rom[0]     = ins(4'h3, 8'h11, 8'h22, 8'h33);
    rom[1]     = ins(4'hD, 8'h00, 8'h00, 8'h20);
    rom[2]     = ins(4'hF, 8'd0, 8'd0, 8'd0);
    rom[16'h20] = ins(4'hF, 8'd0, 8'd0, 8'd0);
    hs0 = hs_cnt;
    i_start = 1'b1; tick; i_start = 1'b0;
    tick; tick; tick;                              // ISSUE
    for (int i = 0; i < 7; i++) begin
      chk("bp_valid", 32'(o_alu_valid), 32'd1);
      chk("bp_fields", 32'({o_alu_op, o_alu_a, o_alu_b, o_alu_c}), 32'({4'h3, 8'h11, 8'h22, 8'h33}));
      if (i == 3) i_start = 1'b1;
      tick;
      i_start = 1'b0;
    end
    chk("bp_valid8", 32'({o_alu_valid, o_pc}), 32'({1'b1, 16'h0000}));
    i_alu_ready = 1'b1; i_alu_done = 1'b1; i_alu_zero = 1'b1;
    tick;                                          // WAIT_RES
    i_alu_ready = 1'b0; i_alu_done = 1'b0; i_alu_zero = 1'b0;
    chk("bp_valid_drop", 32'(o_alu_valid), 32'd0);
    chk("bp_hs", 32'(hs_cnt - hs0), 32'd1);
    tick;
    chk("bp_still_wait", 32'({o_rom_en, o_busy}), 32'({1'b0, 1'b1}));
    i_alu_done = 1'b1; tick; i_alu_done = 1'b0;    // FETCH 1
    tick; tick; tick;                              // LATCH, EXEC, FETCH
    chk("bp_jz_fall", 32'({o_rom_en, o_rom_addr}), 32'({1'b1, 16'h0002}));
    tick; tick; tick;
    chk("bp_done", 32'(o_all_done), 32'd1);

    // Wrap: JMP to FFFF, ALU op there, increment halts instead of wrapping.
    rom[0]       = ins(4'hE, 8'h00, 8'hFF, 8'hFF);
    rom[16'hFFFF] = ins(4'h4, 8'd1, 8'd2, 8'd3);
    i_start = 1'b1; tick; i_start = 1'b0;
    f0 = fetch0_cnt;
    tick; tick; tick;                              // LATCH, EXEC, FETCH FFFF
    chk("w_fetch", 32'({o_rom_en, o_rom_addr}), 32'({1'b1, 16'hFFFF}));
    tick; tick; tick;                              // LATCH, EXEC, ISSUE
    chk("w_issue", 32'({o_alu_valid, o_alu_op}), 32'({1'b1, 4'h4}));
    i_alu_ready = 1'b1; tick; i_alu_ready = 1'b0;
    i_alu_done = 1'b1; tick; i_alu_done = 1'b0;    // DONE
    chk("w_done", 32'({o_all_done, o_rom_en, o_pc}), 32'({1'b1, 1'b0, 16'hFFFF}));
    tick; tick;
    chk("w_no_fetch0", 32'(fetch0_cnt - f0), 32'd1);
    chk("w_stay", 32'(o_all_done), 32'd1);

    // Reset in WAIT_RES, late done ignored, restart from PC 0.
    rom[0] = ins(4'h5, 8'd7, 8'd8, 8'd9);
    rom[1] = ins(4'hF, 8'd0, 8'd0, 8'd0);
    i_start = 1'b1; tick; i_start = 1'b0;
    tick; tick; tick;
    i_alu_ready = 1'b1; tick; i_alu_ready = 1'b0;  // WAIT_RES
    chk("r_wait_busy", 32'(o_busy), 32'd1);
    #2 i_reset_n = 1'b0;
    #1;
    chk_all_zero("r_async");
    tick;
    i_reset_n = 1'b1; i_alu_done = 1'b1; i_alu_zero = 1'b1;
    tick;
    i_alu_done = 1'b0; i_alu_zero = 1'b0;
    chk("r_idle", 32'({o_busy, o_rom_en, o_all_done, o_pc}), 32'd0);
    i_start = 1'b1; tick; i_start = 1'b0;
    chk("r_restart", 32'({o_rom_en, o_rom_addr}), 32'({1'b1, 16'h0000}));
    tick; tick; tick;
    chk("r_issue", 32'({o_alu_valid, o_alu_a}), 32'({1'b1, 8'd7}));
    i_alu_ready = 1'b1; tick; i_alu_ready = 1'b0;
    i_alu_done = 1'b1; tick; i_alu_done = 1'b0;
    tick; tick; tick;
    chk("r_done", 32'({o_all_done, o_pc}), 32'({1'b1, 16'h0001}));

`ifdef MEST_SEQ_WATCHDOG_EN
    // Watchdog: no done, timeout 10 cycles after WAIT_RES entry.
    rom[0] = ins(4'h6, 8'd1, 8'd1, 8'd1);
    rom[1] = ins(4'hF, 8'd0, 8'd0, 8'd0);
    i_start = 1'b1; tick; i_start = 1'b0;
    tick; tick; tick;
    i_alu_ready = 1'b1; tick; i_alu_ready = 1'b0;  // WAIT_RES entry
    repeat (9) tick;
    chk("wd_before", 32'({o_error, o_all_done}), 32'd0);
    tick;
    chk("wd_fire", 32'({o_error, o_all_done, o_busy}), 32'({1'b1, 1'b1, 1'b0}));
    tick;
    chk("wd_sticky", 32'(o_error), 32'd1);
    i_start = 1'b1; tick; i_start = 1'b0;
    chk("wd_clear", 32'({o_error, o_all_done}), 32'd0);
    tick; tick; tick;
    i_alu_ready = 1'b1; tick; i_alu_ready = 1'b0;
    i_alu_done = 1'b1; tick; i_alu_done = 1'b0;
    tick; tick; tick;
    chk("wd_rerun", 32'({o_all_done, o_error}), 32'({1'b1, 1'b0}));
`else
    chk("no_wdog_error", 32'(o_error), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
